// File: rtl/hazard_stall_unit.sv
// Decode-stage pipeline interlock: load-use bubbles, taken-branch flush and data-memory freeze.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LU_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic                  use_rs1_D,
  input  logic                  use_rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic                  isLoadE,
  input  logic                  regWriteE,
  input  logic                  branchTakenE,
  input  logic                  memBusyM,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  flushD,
  output logic                  bubbleE,
  output logic                  bubbleW,
  output logic [1:0]            hzState,
  output logic [31:0]           stallCycles,
  output logic [15:0]           flushCount
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

  hz_state_e state_q, state_d, ret_q, ret_d, cur_state;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;
  logic       stall_f_c, stall_d_c, stall_e_c, stall_m_c;
  logic       flush_d_c, bubble_e_c, bubble_w_c;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    lu_hit = isLoadE && regWriteE && (rd_E != '0) &&
             ((use_rs1_D && (rs1_D == rd_E)) || (use_rs2_D && (rs2_D == rd_E)));

    // Leaving MEM_WAIT behaves exactly like the interrupted state, with no dead cycle.
    cur_state = (state_q == MEM_WAIT && !memBusyM) ? ret_q : state_q;

    state_d    = cur_state;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    stall_f_c  = 1'b0;
    stall_d_c  = 1'b0;
    stall_e_c  = 1'b0;
    stall_m_c  = 1'b0;
    flush_d_c  = 1'b0;
    bubble_e_c = 1'b0;
    bubble_w_c = 1'b0;

    if (memBusyM) begin
      // Freeze everything; Execute re-presents any branch once memory completes.
      stall_f_c  = 1'b1;
      stall_d_c  = 1'b1;
      stall_e_c  = 1'b1;
      stall_m_c  = 1'b1;
      bubble_w_c = 1'b1;
      if (cur_state != MEM_WAIT) ret_d = cur_state;
      state_d = MEM_WAIT;
    end else begin
      unique case (cur_state)
        RUN: begin
          if (branchTakenE) begin
            flush_d_c  = 1'b1;
            bubble_e_c = 1'b1;
          end else if (lu_hit) begin
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            bubble_e_c = 1'b1;
            if (LU_BUBBLES > 1) begin
              cnt_d   = 3'(LU_BUBBLES - 1);
              state_d = LU_STALL;
            end
          end
        end
        LU_STALL: begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          bubble_e_c = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign stallF  = rst_n & stall_f_c;
  assign stallD  = rst_n & stall_d_c;
  assign stallE  = rst_n & stall_e_c;
  assign stallM  = rst_n & stall_m_c;
  assign flushD  = rst_n & flush_d_c;
  assign bubbleE = rst_n & bubble_e_c;
  assign bubbleW = rst_n & bubble_w_c;
  assign hzState = rst_n ? cur_state : RUN;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_d_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule
